wld_handshake_ctrl: RTL

Sequencing controller for the picoMIPS wait-and-load instructions (WLD0, WLD1). Synchronises and debounces the raw handshake switch, stalls the program counter while a WLD instruction waits for the required switch level, then issues a single-cycle load enable so the register file captures the switch data. Sits between the instruction decoder and the PC/register-file write path; the decoder's `pc_inc` is ANDed with `!pc_stall` at top level.

---
 rtl/picomips_ctrl_pkg.sv | 32 +++
 rtl/wld_handshake_ctrl_sw_debounce.sv | 45 ++++
 rtl/wld_handshake_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/picomips_ctrl_pkg.sv
// Shared control definitions for the picoMIPS sequencing logic: opcode
// constants used by the controllers and the WLD handshake state encoding.
`ifndef OPCODE_SIZE
`define OPCODE_SIZE 3
`endif

package picomips_ctrl_pkg;

  localparam int OPCODE_W = `OPCODE_SIZE;

  typedef logic [OPCODE_W-1:0] opcode_t;

  // Core opcode map of the picoMIPS instruction set
  localparam opcode_t OP_ADD   = opcode_t'(0);
  localparam opcode_t OP_ADDI  = opcode_t'(1);
  localparam opcode_t OP_MULT  = opcode_t'(2);
  localparam opcode_t OP_MULTI = opcode_t'(3);
  localparam opcode_t OP_WLD0  = opcode_t'(4);
  localparam opcode_t OP_WLD1  = opcode_t'(5);

  // Wait-and-load opcodes as seen by the handshake controller
  localparam opcode_t WLD0 = OP_WLD0;
  localparam opcode_t WLD1 = OP_WLD1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    LOAD = 2'd2,
    TMO  = 2'd3
  } wld_state_t;

endpackage

// File: rtl/wld_handshake_ctrl_sw_debounce.sv
// Two-flop synchroniser followed by a debounce counter for the raw
// handshake switch. The debounced level only changes after DEBOUNCE_CYCLES
// consecutive synchronised samples disagree with it.
module sw_debounce
  import picomips_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic nReset,
  input  logic sw8,
  output logic sw_level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          sw_sync;
  logic [CW-1:0] cnt;

  assign sw_sync = sync_q[1];

  // Synchronise the switch, then count consecutive disagreeing samples
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      sync_q   <= 2'b00;
      sw_level <= 1'b0;
      cnt      <= '0;
    end else begin
      sync_q <= {sync_q[0], sw8};
      if (sw_sync != sw_level) begin
        if (cnt == CNT_MAX) begin
          sw_level <= ~sw_level;
          cnt      <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/wld_handshake_ctrl.sv
// Wait-and-load sequencing controller for WLD0/WLD1. Stalls the PC while a
// WLD waits for the debounced switch to reach the required level, then
// issues a one-cycle register-file load enable.
// Optional feature: define WAIT_TIMEOUT_EN to abandon a wait after
// TIMEOUT_CYCLES cycles (pulses timeout_err, releases the stall, no load).
module wld_handshake_ctrl
  import picomips_ctrl_pkg::*;
#(
  parameter int OPCODE_SIZE     = `OPCODE_SIZE,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                   clk,
  input  logic                   nReset,
  input  logic [OPCODE_SIZE-1:0] opcode,
  input  logic                   sw8,
  output logic                   pc_stall,
  output logic                   load_en,
  output logic                   sw_level,
  output logic                   timeout_err
);

  localparam logic [OPCODE_SIZE-1:0] WLD0_OP = OPCODE_SIZE'(WLD0);
  localparam logic [OPCODE_SIZE-1:0] WLD1_OP = OPCODE_SIZE'(WLD1);

  wld_state_t state, state_nxt;
  logic       target;
  logic       is_wld;

  assign is_wld = (opcode == WLD0_OP) || (opcode == WLD1_OP);

  sw_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sw_debounce (
    .clk     (clk),
    .nReset  (nReset),
    .sw8     (sw8),
    .sw_level(sw_level)
  );

`ifdef WAIT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt;

  // Wait-cycle counter: held at zero outside WAIT so it restarts on entry
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      tmo_cnt <= '0;
    end else if (state == WAIT) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

  // State register and latch of the switch level the WLD is waiting for
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state  <= IDLE;
      target <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && is_wld) begin
        target <= (opcode == WLD1_OP);
      end
    end
  end

  // Next-state and output decode; the IDLE stall is gated by nReset so the
  // stall drops the instant reset is asserted even with a WLD on the bus
  always_comb begin
    state_nxt = state;
    pc_stall  = 1'b0;
    load_en   = 1'b0;
`ifdef WAIT_TIMEOUT_EN
    timeout_err = 1'b0;
`endif
    case (state)
      IDLE: begin
        pc_stall = is_wld && nReset;
        if (is_wld) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        pc_stall = 1'b1;
        if (sw_level == target) begin
          state_nxt = LOAD;
`ifdef WAIT_TIMEOUT_EN
        end else if (tmo_cnt == TMO_MAX) begin
          state_nxt = TMO;
`endif
        end
      end
      LOAD: begin
        load_en   = 1'b1;
        state_nxt = IDLE;
      end
`ifdef WAIT_TIMEOUT_EN
      TMO: begin
        timeout_err = 1'b1;
        state_nxt   = IDLE;
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
